// File: rtl/alu_interface.sv
// Byte-serial front end for the combinational ALU: gathers A, B and opcode from
// UART RX, latches the ALU result, and hands it to UART TX with a one-cycle start.
module alu_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_AB   = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_AB-1:0]   i_alu_result,
    output logic [NB_AB-1:0]   o_A,
    output logic [NB_AB-1:0]   o_B,
    output logic [NB_OP-1:0]   o_opcode,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start
);

    typedef enum logic [2:0] {
        GET_A, GET_B, GET_OP, CALC, SEND, WAIT_TX
    } state_t;

    state_t state, next_state;
    logic   load_a, load_b, load_op;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= GET_A;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        case (state)
            GET_A:   if (i_rx_done) begin load_a  = 1'b1; next_state = GET_B;  end
            GET_B:   if (i_rx_done) begin load_b  = 1'b1; next_state = GET_OP; end
            GET_OP:  if (i_rx_done) begin load_op = 1'b1; next_state = CALC;   end
            CALC:    next_state = SEND;
            SEND:    next_state = WAIT_TX;
            // RX bytes arriving here are dropped, even alongside i_tx_done.
            WAIT_TX: if (i_tx_done) next_state = GET_A;
            default: next_state = GET_A;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_A        <= '0;
            o_B        <= '0;
            o_opcode   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            if (load_a)  o_A      <= i_rx_data[NB_AB-1:0];
            if (load_b)  o_B      <= i_rx_data[NB_AB-1:0];
            if (load_op) o_opcode <= i_rx_data[NB_OP-1:0];
            // Operands have been stable for a full cycle by the end of CALC.
            if (state == CALC) o_tx_data <= NB_DATA'($signed(i_alu_result));
            // Registered start: high exactly for the SEND cycle.
            o_tx_start <= (state == CALC);
        end
    end

endmodule
